bit_scan_64b: RTL and testbench



---
 rtl/bit_scan_64b.sv | 176 +++++++++++++++++
 tb/tb_bit_scan_64b.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_scan_64b.sv
// bit_scan_64b -- set-bit sequencer built on a 64-bit priority encoder.
// It accepts a 64-bit mask and then emits the index of each set bit, one
// index per beat, on a valid/ready stream. Each emitted bit is cleared from
// the internal mask. When the mask is empty the block is ready for a new word.
//
// Ports of bit_scan_64b:
//   clk_i, rst_n_i             clock, asynchronous active-low reset
//   in_data_i/in_valid_i       mask to scan and its valid flag
//   in_ready_o                 high when the block can accept a word (IDLE)
//   flush_i                    synchronous abort of the current word
//   out_data_o                 index of the current set bit
//   out_seq_o                  beat number within the word
//   out_last_o                 high on the final beat of the word
//   out_empty_o                high when the accepted word was all-zero
//   out_valid_o/out_ready_i    output beat handshake
//   busy_o                     high while a word is being scanned
//
// Ports of enc_64b:
//   clk_i, rst_n_i             used only when REG_OUT=1
//   in_data_i                  vector to encode
//   idx_o                      index of the highest set bit (0 when none)
//   valid_o                    high when any bit is set

module enc_64b #(
  parameter bit REG_OUT = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] in_data_i,
  output logic [5:0]  idx_o,
  output logic        valid_o
);

  logic [5:0] idx_c;
  logic       valid_c;
  logic [5:0] idx_q;
  logic       valid_q;

  // The highest set bit wins because later loop iterations overwrite earlier ones.
  always_comb begin
    idx_c   = 6'd0;
    valid_c = |in_data_i;
    for (int i = 0; i < 64; i++) begin
      if (in_data_i[i]) idx_c = 6'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q   <= 6'd0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_c;
      valid_q <= valid_c;
    end
  end

  assign idx_o   = REG_OUT ? idx_q   : idx_c;
  assign valid_o = REG_OUT ? valid_q : valid_c;

endmodule

// state | meaning
// IDLE  | waiting for a word; in_ready_o high
// SCAN  | presenting one beat per set bit of mask_r (or one empty beat)
module bit_scan_64b #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        flush_i,
  output logic [5:0]  out_data_o,
  output logic [6:0]  out_seq_o,
  output logic        out_last_o,
  output logic        out_empty_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state_r, state_n;
  logic [63:0] mask_r, mask_n;
  logic [6:0]  seq_r, seq_n;
  logic        empty_r, empty_n;

  logic [63:0] mask_rev;
  logic [63:0] enc_in;
  logic [5:0]  enc_idx;
  logic        enc_valid;
  logic [5:0]  idx_raw;
  logic        single;
  logic        scan;
  logic        hs;

  // Feeding the bit-reversed mask to the encoder turns the search for the
  // highest set bit into a search for the lowest set bit of the original.
  always_comb begin
    mask_rev = '0;
    for (int i = 0; i < 64; i++) mask_rev[i] = mask_r[63-i];
  end

  assign enc_in = MSB_FIRST ? mask_r : mask_rev;

  enc_64b #(.REG_OUT(1'b0)) u_enc (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .in_data_i (enc_in),
    .idx_o     (enc_idx),
    .valid_o   (enc_valid)
  );

  assign idx_raw = MSB_FIRST ? enc_idx : (6'd63 - enc_idx);
  // x & (x-1) clears the lowest set bit, so it is zero when only one bit is set.
  assign single  = enc_valid && ((mask_r & (mask_r - 64'd1)) == 64'd0);
  assign scan    = (state_r == SCAN);
  assign hs      = scan && out_ready_i;

  assign in_ready_o  = !scan;
  assign busy_o      = scan;
  assign out_valid_o = scan;
  assign out_data_o  = (scan && !empty_r) ? idx_raw : 6'd0;
  assign out_seq_o   = scan ? seq_r : 7'd0;
  assign out_last_o  = scan && (empty_r || single);
  assign out_empty_o = scan && empty_r;

  always_comb begin
    state_n = state_r;
    mask_n  = mask_r;
    seq_n   = seq_r;
    empty_n = empty_r;
    case (state_r)
      IDLE: begin
        if (!flush_i && in_valid_i) begin
          mask_n  = in_data_i;
          seq_n   = 7'd0;
          empty_n = (in_data_i == 64'd0);
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (hs) begin
          mask_n = mask_r & ~(64'd1 << out_data_o);
          seq_n  = seq_r + 7'd1;
          if (out_last_o) state_n = IDLE;
        end
        // A beat that hands off together with a flush has still been delivered.
        if (flush_i) begin
          state_n = IDLE;
          mask_n  = 64'd0;
          empty_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
      mask_r  <= 64'd0;
      seq_r   <= 7'd0;
      empty_r <= 1'b0;
    end else begin
      state_r <= state_n;
      mask_r  <= mask_n;
      seq_r   <= seq_n;
      empty_r <= empty_n;
    end
  end

endmodule

// File: tb/tb_bit_scan_64b.sv
module tb_bit_scan_64b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic        in_valid;
  logic        flush;
  logic        out_ready;

  logic       rdy1, val1, last1, emp1, busy1;
  logic [5:0] dat1;
  logic [6:0] seq1;
  logic       rdy0, val0, last0, emp0, busy0;
  logic [5:0] dat0;
  logic [6:0] seq0;

  int total = 0;
  int bad   = 0;

  // expected beat = {index[5:0], seq[6:0], last, empty}
  typedef logic [14:0] beat_t;
  beat_t q1[$];
  beat_t q0[$];

  always #5 clk = ~clk;

  bit_scan_64b #(.MSB_FIRST(1'b1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(rdy1), .flush_i(flush), .out_data_o(dat1), .out_seq_o(seq1),
    .out_last_o(last1), .out_empty_o(emp1), .out_valid_o(val1),
    .out_ready_i(out_ready), .busy_o(busy1)
  );

  bit_scan_64b #(.MSB_FIRST(1'b0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(rdy0), .flush_i(flush), .out_data_o(dat0), .out_seq_o(seq0),
    .out_last_o(last0), .out_empty_o(emp0), .out_valid_o(val0),
    .out_ready_i(out_ready), .busy_o(busy0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: list the set bits in the order each instance must emit them.
  task automatic push_word(input logic [63:0] w);
    int n;
    int k;
    n = $countones(w);
    if (w == 64'd0) begin
      q1.push_back({6'd0, 7'd0, 1'b1, 1'b1});
      q0.push_back({6'd0, 7'd0, 1'b1, 1'b1});
    end else begin
      k = 0;
      for (int i = 63; i >= 0; i--) begin
        if (w[i]) begin
          q1.push_back({6'(i), 7'(k), 1'(k == n - 1), 1'b0});
          k++;
        end
      end
      k = 0;
      for (int i = 0; i < 64; i++) begin
        if (w[i]) begin
          q0.push_back({6'(i), 7'(k), 1'(k == n - 1), 1'b0});
          k++;
        end
      end
    end
  endtask

  task automatic send(input logic [63:0] w, input bit model);
    int budget;
    budget = 50;
    while (!(rdy1 && rdy0) && budget > 0) begin
      step(1);
      budget--;
    end
    chk("send_ready_timeout", 64'(rdy1 && rdy0), 64'd1);
    in_data  = w;
    in_valid = 1'b1;
    if (model) push_word(w);
    step(1);
    in_valid = 1'b0;
    in_data  = 64'd0;
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 200;
    while ((busy1 || busy0) && budget > 0) begin
      step(1);
      budget--;
    end
    chk(tag, 64'(busy1 || busy0), 64'd0);
  endtask

  // Scoreboard: a beat is compared when it is about to hand off.
  always @(negedge clk) begin
    if (rst_n && out_ready && val1) begin
      total++;
      assert (q1.size() != 0) else begin
        bad++;
        $error("FAIL msb1_extra_beat observed=%0h expected=none", {dat1, seq1, last1, emp1});
      end
      if (q1.size() != 0) chk("msb1_beat", {dat1, seq1, last1, emp1}, q1.pop_front());
    end
    if (rst_n && out_ready && val0) begin
      total++;
      assert (q0.size() != 0) else begin
        bad++;
        $error("FAIL msb0_extra_beat observed=%0h expected=none", {dat0, seq0, last0, emp0});
      end
      if (q0.size() != 0) chk("msb0_beat", {dat0, seq0, last0, emp0}, q0.pop_front());
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = 64'd0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", {rdy1, rdy0}, 2'b11);
    chk("rst_out_valid", {val1, val0}, 2'b00);
    chk("rst_data", {dat1, dat0}, 12'd0);
    chk("rst_seq", {seq1, seq0}, 14'd0);
    chk("rst_last_empty_busy", {last1, last0, emp1, emp0, busy1, busy0}, 6'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Three set bits; in_ready low for 3 cycles after accept.
    send(64'h8000_0000_0000_0011, 1'b1);
    chk("first_beat_latency", {val1, dat1, seq1}, {1'b1, 6'd63, 7'd0});
    chk("ready_low_c1", rdy1, 1'b0);
    step(1);
    chk("ready_low_c2", rdy1, 1'b0);
    step(1);
    chk("ready_low_c3", rdy1, 1'b0);
    step(1);
    chk("ready_high_c4", {rdy1, rdy0}, 2'b11);
    chk("after_word_queues", q1.size() + q0.size(), 0);

    // Zero word: one empty beat.
    send(64'd0, 1'b1);
    chk("zero_beat", {val1, dat1, seq1, last1, emp1}, {1'b1, 6'd0, 7'd0, 1'b1, 1'b1});
    step(1);
    chk("zero_back_idle", {busy1, busy0, rdy1, rdy0}, 4'b0011);

    // All-ones with a 3-cycle stall on beat 5.
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    step(5);
    out_ready = 1'b0;
    chk("stall_beat5", {dat1, seq1, dat0, seq0}, {6'd58, 7'd5, 6'd5, 7'd5});
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_hold", {val1, dat1, seq1, last1, emp1}, {1'b1, 6'd58, 7'd5, 1'b0, 1'b0});
    end
    out_ready = 1'b1;
    wait_idle("ones_idle_timeout");
    chk("ones_queues_drained", q1.size() + q0.size(), 0);

    // Flush coinciding with the second beat of 0xF0.
    send(64'hF0, 1'b0);
    q1.push_back({6'd7, 7'd0, 1'b0, 1'b0});
    q1.push_back({6'd6, 7'd1, 1'b0, 1'b0});
    q0.push_back({6'd4, 7'd0, 1'b0, 1'b0});
    q0.push_back({6'd5, 7'd1, 1'b0, 1'b0});
    step(1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_valid_drop", {val1, val0}, 2'b00);
    chk("flush_ready", {rdy1, rdy0}, 2'b11);
    chk("flush_queues", q1.size() + q0.size(), 0);
    send(64'h1, 1'b1);
    chk("post_flush_beat", {dat1, seq1, last1, dat0, seq0, last0},
        {6'd0, 7'd0, 1'b1, 6'd0, 7'd0, 1'b1});
    step(1);

    // Flush in IDLE blocks acceptance.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'h3;
    step(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_idle_no_accept", {busy1, busy0}, 2'b00);

    // Asynchronous reset mid-scan.
    send(64'hFF, 1'b1);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {val1, val0}, 2'b00);
    q1.delete();
    q0.delete();
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("post_rst_quiet", {rdy1, rdy0, val1, val0}, 4'b1100);
    end

    send(64'h0000_0001_0000_0000, 1'b1);
    wait_idle("final_idle_timeout");
    step(1);
    chk("final_queues", q1.size() + q0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
